// File: rtl/cluster_eval_sequencer_if.sv
// Handshake and evaluator-bank bundle between the sequencer and its neighbours.
// The master modport is the sequencer's view; the slave modport is everything around it.
interface cluster_eval_sequencer_if #(
    parameter int IN_W  = 1894,
    parameter int OUT_W = 128,
    parameter int GRP_W = 8,
    parameter int NGRP  = OUT_W / GRP_W,
    parameter int GW    = (NGRP > 1) ? $clog2(NGRP) : 1
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_vec;
    logic [IN_W-1:0]         ev_vec;
    logic [GW-1:0]           ev_grp;
    logic [GRP_W-1:0]        ev_bits;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_vec;
    logic                    busy;
    logic [31:0]             vec_cnt;

    modport master (
        input  flush, in_valid, in_vec, ev_bits, out_ready,
        output in_ready, ev_vec, ev_grp, out_valid, out_vec, busy, vec_cnt
    );

    modport slave (
        output flush, in_valid, in_vec, ev_bits, out_ready,
        input  in_ready, ev_vec, ev_grp, out_valid, out_vec, busy, vec_cnt
    );
endinterface

// File: rtl/cluster_eval_sequencer.sv
// Shares one output-bit evaluator bank across all groups: latches an input vector,
// walks the group index, and assembles the returned bits into a held result word.
module cluster_eval_sequencer #(
    parameter int IN_W  = 1894,
    parameter int OUT_W = 128,
    parameter int GRP_W = 8,
    parameter int NGRP  = OUT_W / GRP_W,
    parameter int GW    = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input logic                      clk,
    input logic                      rst_n,
    cluster_eval_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   ev_vec_q, ev_vec_d;
    logic [GW-1:0]     ev_grp_q, ev_grp_d;
    logic [OUT_W-1:0]  out_vec_q, out_vec_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       vec_cnt_q, vec_cnt_d;
    logic              in_ready_c;
    logic              busy_c;
    logic [31:0]       grp_base;

    assign grp_base = 32'(ev_grp_q) * 32'(GRP_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ev_vec_q    <= '0;
            ev_grp_q    <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            vec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ev_vec_q    <= ev_vec_d;
            ev_grp_q    <= ev_grp_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ev_vec_d    = ev_vec_q;
        ev_grp_d    = ev_grp_q;
        out_vec_d   = out_vec_q;
        out_valid_d = out_valid_q;
        vec_cnt_d   = vec_cnt_q;
        in_ready_c  = 1'b0;
        busy_c      = (state_q != IDLE);

        // Abort wins over any handshake, including a completing output one.
        if (bus.flush) begin
            state_d     = IDLE;
            ev_grp_d    = '0;
            out_vec_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        ev_vec_d = bus.in_vec;
                        ev_grp_d = '0;
                        state_d  = EVAL;
                    end
                end

                EVAL: begin
                    out_vec_d[grp_base +: GRP_W] = bus.ev_bits;
                    if (ev_grp_q == LAST_GRP) begin
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        ev_grp_d = ev_grp_q + GW'(1);
                    end
                end

                HOLD: begin
                    // Accepting only alongside the output handshake lets vectors run back to back.
                    in_ready_c = bus.out_ready;
                    if (bus.out_ready) begin
                        vec_cnt_d   = vec_cnt_q + 32'd1;
                        out_valid_d = 1'b0;
                        if (bus.in_valid) begin
                            ev_vec_d = bus.in_vec;
                            ev_grp_d = '0;
                            state_d  = EVAL;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.ev_vec    = ev_vec_q;
    assign bus.ev_grp    = ev_grp_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_cluster_eval_sequencer.sv
// Directed-plus-random bench for cluster_eval_sequencer with a stub evaluator bank
// and a whole-word reference model of the assembled result.
module tb_cluster_eval_sequencer;

    localparam int IN_W  = 1894;
    localparam int OUT_W = 128;
    localparam int GRP_W = 8;
    localparam int NGRP  = OUT_W / GRP_W;
    localparam int GW    = $clog2(NGRP);

    logic clk;
    logic rst_n;
    int   mode;
    int   n_cmp;
    int   n_fail;
    logic [31:0] exp_cnt;

    cluster_eval_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .GRP_W(GRP_W)) bus ();

    cluster_eval_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .GRP_W(GRP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Evaluator stub: mode 0 is the fixed g*17 pattern, mode 1 depends on the operand.
    function automatic logic [GRP_W-1:0] evalf(input int m, input logic [IN_W-1:0] v, input int g);
        logic [GRP_W-1:0] k;
        k = 8'((g * 17) % 256);
        if (m == 0) return k;
        return v[g*GRP_W +: GRP_W] ^ v[IN_W-1-g -: GRP_W] ^ k;
    endfunction

    always_comb bus.ev_bits = evalf(mode, bus.ev_vec, int'(bus.ev_grp));

    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int g = 0; g < NGRP; g++) r[g*GRP_W +: GRP_W] = evalf(mode, v, g);
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rvec();
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE, holding the result for 'stall' cycles.
    task automatic run_vec(input string tag, input logic [IN_W-1:0] v, input int stall);
        int n;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        #1;
        chk({tag, "_in_ready_idle"}, 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.in_vec   = rvec();
        chk({tag, "_grp_start"}, 128'(bus.ev_grp), 128'(0));
        chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(NGRP + 1));
        chk({tag, "_result"}, bus.out_vec, model(v));
        repeat (stall) tick();
        chk({tag, "_held"}, bus.out_vec, model(v));
        chk({tag, "_valid_held"}, 128'(bus.out_valid), 128'(1));
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready_hold"}, 128'(bus.in_ready), 128'(1));
        tick();
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk({tag, "_valid_drop"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_vec_cnt"}, 128'(bus.vec_cnt), 128'(exp_cnt));
        chk({tag, "_idle"}, 128'(bus.busy), 128'(0));
    endtask

    logic [IN_W-1:0]  va, vb;
    logic [IN_W-1:0]  vecs [4];
    logic [OUT_W-1:0] held;
    int acc, got, cyc, last_t, n;
    logic hs_in, hs_out;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_cnt = '0;
        mode = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_vec", bus.out_vec, 128'(0));
        chk("rst_ev_grp", 128'(bus.ev_grp), 128'(0));
        chk("rst_ev_vec_zero", 128'(bus.ev_vec == '0), 128'(1));
        chk("rst_vec_cnt", 128'(bus.vec_cnt), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        tick();

        // Fixed-pattern evaluator, single vector
        va = rvec();
        run_vec("single", va, 0);
        chk("single_byte0", 128'(model(va)[7:0]), 128'(8'h00));
        held = model(va);
        chk("single_pattern_hi", 128'({held[127:120], held[15:8]}), 128'(16'hFF11));

        mode = 1;

        // Back-to-back with both handshakes held open
        for (int i = 0; i < 4; i++) vecs[i] = rvec();
        acc = 0; got = 0; cyc = 0; last_t = -1;
        bus.out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            bus.in_valid = (acc < 4);
            bus.in_vec   = vecs[(acc < 4) ? acc : 0];
            #1;
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (hs_out) begin
                chk("b2b_result", bus.out_vec, model(vecs[got]));
                if (got > 0) chk("b2b_interval", 128'(cyc - last_t), 128'(NGRP + 1));
                last_t = cyc;
                got++;
            end
            if (hs_in) acc++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd4;
        chk("b2b_count", 128'(got), 128'(4));
        chk("b2b_vec_cnt", 128'(bus.vec_cnt), 128'(exp_cnt));

        // Backpressure in HOLD with a new vector waiting
        va = rvec();
        vb = rvec();
        bus.in_valid = 1'b1;
        bus.in_vec = va;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("bp_reach_hold", 128'(bus.out_valid), 128'(1));
        held = bus.out_vec;
        chk("bp_result", held, model(va));
        bus.in_valid = 1'b1;
        bus.in_vec = vb;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
            tick();
            chk("bp_out_vec_stable", bus.out_vec, held);
            chk("bp_ev_vec_stable", 128'(bus.ev_vec == va), 128'(1));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(bus.in_ready), 128'(1));
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("bp_vec_cnt", 128'(bus.vec_cnt), 128'(exp_cnt));
        chk("bp_valid_drop", 128'(bus.out_valid), 128'(0));
        chk("bp_captured", 128'(bus.ev_vec == vb), 128'(1));
        chk("bp_grp0", 128'(bus.ev_grp), 128'(0));
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("bp_second_latency", 128'(n), 128'(NGRP + 1));
        chk("bp_second_result", bus.out_vec, model(vb));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("bp_second_cnt", 128'(bus.vec_cnt), 128'(exp_cnt));

        // Flush mid-EVAL at group 5
        bus.in_valid = 1'b1;
        bus.in_vec = rvec();
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.ev_grp !== GW'(5) && n < 40) begin tick(); n++; end
        chk("fl_reach_grp5", 128'(bus.ev_grp), 128'(5));
        bus.flush = 1'b1;
        #1;
        chk("fl_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        bus.flush = 1'b0;
        chk("fl_idle", 128'(bus.busy), 128'(0));
        chk("fl_out_valid", 128'(bus.out_valid), 128'(0));
        chk("fl_out_vec", bus.out_vec, 128'(0));
        chk("fl_ev_grp", 128'(bus.ev_grp), 128'(0));
        chk("fl_vec_cnt", 128'(bus.vec_cnt), 128'(exp_cnt));
        run_vec("after_flush", rvec(), 2);

        // Flush in HOLD racing a completing output handshake
        bus.in_valid = 1'b1;
        bus.in_vec = rvec();
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("flh_reach_hold", 128'(bus.out_valid), 128'(1));
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("flh_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flh_out_valid", 128'(bus.out_valid), 128'(0));
        chk("flh_vec_cnt", 128'(bus.vec_cnt), 128'(exp_cnt));
        chk("flh_idle", 128'(bus.busy), 128'(0));

        // Flush in IDLE blocks a capture
        va = bus.ev_vec;
        bus.in_valid = 1'b1;
        bus.in_vec = rvec();
        bus.flush = 1'b1;
        #1;
        chk("fli_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fli_no_capture", 128'(bus.busy), 128'(0));
        chk("fli_ev_vec", 128'(bus.ev_vec == va), 128'(1));

        // Asynchronous reset mid-EVAL, between clock edges
        bus.in_valid = 1'b1;
        bus.in_vec = rvec();
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_out_vec", bus.out_vec, 128'(0));
        chk("arst_ev_grp", 128'(bus.ev_grp), 128'(0));
        chk("arst_ev_vec", 128'(bus.ev_vec == '0), 128'(1));
        chk("arst_vec_cnt", 128'(bus.vec_cnt), 128'(0));
        chk("arst_busy", 128'(bus.busy), 128'(0));
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
        tick();
        run_vec("after_rst", rvec(), 1);

        // Counter wrap
        force dut.vec_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.vec_cnt_q;
        #1;
        chk("wrap_preload", 128'(bus.vec_cnt), 128'(32'hFFFF_FFFF));
        exp_cnt = 32'hFFFF_FFFF;
        run_vec("wrap", rvec(), 0);
        chk("wrap_zero", 128'(bus.vec_cnt), 128'(0));

        // Random transactions with random backpressure
        for (int i = 0; i < 4; i++) begin
            mode = int'($urandom_range(0, 1));
            run_vec("rand", rvec(), int'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
